// File: rtl/bomb_controller_if.sv
// Bundle of signals between the bomb controller and its puzzle modules.
// The controller owns setup values and enables; modules report strike/defused levels.
interface bomb_controller_if #(
    parameter int NUM_MODULES = 4
);
    logic [NUM_MODULES-1:0] module_strike;
    logic [NUM_MODULES-1:0] module_defused;
    logic [NUM_MODULES-1:0] module_enable;
    logic [NUM_MODULES-1:0] rng_load;
    logic [3:0]             rng_output;

    modport master (
        input  module_strike,
        input  module_defused,
        output module_enable,
        output rng_load,
        output rng_output
    );

    modport slave (
        output module_strike,
        output module_defused,
        input  module_enable,
        input  rng_load,
        input  rng_output
    );
endinterface

// File: rtl/bomb_controller.sv
// Game master: seeds puzzle modules, counts strikes, runs the countdown and
// decides whether the bomb is defused or explodes.
//
// state    | meaning
// IDLE     | waiting for start
// SETUP    | loading one random value per module, one module per cycle
// ARMED    | modules enabled, strikes and timer live
// DEFUSED  | every module solved before explosion; terminal until reset
// EXPLODED | strike limit or timer hit zero; terminal until reset
module bomb_controller #(
    parameter int             NUM_MODULES   = 4,
    parameter int             CLK_FREQ      = 27000000,
    parameter int             TIMER_SECONDS = 300,
    parameter int             MAX_STRIKES   = 3,
    parameter logic [15:0]    LFSR_SEED     = 16'hACE1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    bomb_controller_if.master      mod_bus,
    output logic [2:0]             game_state,
    output logic [1:0]             strikes,
    output logic                   strike_pulse,
    output logic [9:0]             seconds_left,
    output logic                   second_tick
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SETUP    = 3'd1,
        ARMED    = 3'd2,
        DEFUSED  = 3'd3,
        EXPLODED = 3'd4
    } state_t;

    localparam int              PW          = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]   PRESC_LAST  = PW'(CLK_FREQ - 1);
    localparam logic [9:0]      TIMER_INIT  = 10'(TIMER_SECONDS);
    localparam logic [1:0]      STRIKE_MAX  = 2'(MAX_STRIKES);
    localparam logic [2:0]      IDX_LAST    = 3'(NUM_MODULES - 1);

    state_t                  state_q, state_d;
    logic [2:0]              idx_q, idx_d;
    logic [15:0]             lfsr_q;
    logic [PW-1:0]           prescaler_q, prescaler_d;
    logic [NUM_MODULES-1:0]  strike_d_q;
    logic [NUM_MODULES-1:0]  new_strike;
    logic [NUM_MODULES-1:0]  enable_q, enable_d;
    logic [NUM_MODULES-1:0]  rng_load_q, rng_load_d;
    logic [3:0]              rng_output_q, rng_output_d;
    logic [1:0]              strikes_q, strikes_d, strikes_upd;
    logic                    pulse_q, pulse_d;
    logic                    tick_q, tick_d;
    logic [9:0]              seconds_q, seconds_d;
    logic [3:0]              n_new;
    logic [3:0]              strike_sum;
    logic                    explode;

    assign new_strike = mod_bus.module_strike & ~strike_d_q;

    // Simultaneous edges from several modules each count, saturating at the limit.
    always_comb begin
        n_new = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            n_new = n_new + 4'(new_strike[i]);
        end
        strike_sum = {2'b00, strikes_q} + n_new;
        if (strike_sum >= 4'(MAX_STRIKES)) begin
            strikes_upd = STRIKE_MAX;
        end else begin
            strikes_upd = strike_sum[1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            lfsr_q       <= LFSR_SEED;
            prescaler_q  <= '0;
            strike_d_q   <= '0;
            enable_q     <= '0;
            rng_load_q   <= '0;
            rng_output_q <= '0;
            strikes_q    <= '0;
            pulse_q      <= 1'b0;
            tick_q       <= 1'b0;
            seconds_q    <= TIMER_INIT;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            lfsr_q       <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            prescaler_q  <= prescaler_d;
            strike_d_q   <= mod_bus.module_strike;
            enable_q     <= enable_d;
            rng_load_q   <= rng_load_d;
            rng_output_q <= rng_output_d;
            strikes_q    <= strikes_d;
            pulse_q      <= pulse_d;
            tick_q       <= tick_d;
            seconds_q    <= seconds_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        prescaler_d  = prescaler_q;
        enable_d     = enable_q;
        rng_load_d   = '0;
        rng_output_d = rng_output_q;
        strikes_d    = strikes_q;
        pulse_d      = 1'b0;
        tick_d       = 1'b0;
        seconds_d    = seconds_q;
        explode      = 1'b0;
        case (state_q)
            IDLE: begin
                enable_d = '0;
                if (start) begin
                    state_d      = SETUP;
                    idx_d        = '0;
                    rng_load_d   = NUM_MODULES'(1);
                    rng_output_d = lfsr_q[3:0];
                    seconds_d    = TIMER_INIT;
                    strikes_d    = '0;
                end
            end
            SETUP: begin
                if (idx_q == IDX_LAST) begin
                    state_d     = ARMED;
                    enable_d    = '1;
                    prescaler_d = '0;
                end else begin
                    idx_d        = idx_q + 3'd1;
                    rng_load_d   = NUM_MODULES'(1) << idx_d;
                    rng_output_d = lfsr_q[3:0];
                end
            end
            ARMED: begin
                strikes_d = strikes_upd;
                pulse_d   = |new_strike;
                if (prescaler_q == PRESC_LAST) begin
                    prescaler_d = '0;
                    tick_d      = 1'b1;
                    if (seconds_q != 10'd0) begin
                        seconds_d = seconds_q - 10'd1;
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
                // A strike-out or timeout beats a defuse landing in the same cycle.
                explode = (strikes_upd == STRIKE_MAX) || (tick_d && (seconds_q == 10'd1));
                if (explode) begin
                    state_d  = EXPLODED;
                    enable_d = '0;
                end else if (&mod_bus.module_defused) begin
                    state_d  = DEFUSED;
                    enable_d = '0;
                end
            end
            DEFUSED, EXPLODED: begin
                enable_d = '0;
            end
            default: begin
                state_d  = IDLE;
                enable_d = '0;
            end
        endcase
    end

    assign game_state             = state_q;
    assign strikes                = strikes_q;
    assign strike_pulse           = pulse_q;
    assign seconds_left           = seconds_q;
    assign second_tick            = tick_q;
    assign mod_bus.module_enable  = enable_q;
    assign mod_bus.rng_load       = rng_load_q;
    assign mod_bus.rng_output     = rng_output_q;
endmodule

// File: tb/tb_bomb_controller.sv
// Directed bench for bomb_controller with a short timer (CLK_FREQ=10, 3 seconds)
// and a reference LFSR to predict the setup values.
module tb_bomb_controller;
    localparam int          NM   = 4;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [2:0] game_state;
    logic [1:0] strikes;
    logic       strike_pulse;
    logic [9:0] seconds_left;
    logic       second_tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m_prev;
    logic [3:0]  last_rng;

    bomb_controller_if #(.NUM_MODULES(NM)) bus ();

    bomb_controller #(
        .NUM_MODULES   (NM),
        .CLK_FREQ      (10),
        .TIMER_SECONDS (3),
        .MAX_STRIKES   (3),
        .LFSR_SEED     (SEED)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .mod_bus      (bus),
        .game_state   (game_state),
        .strikes      (strikes),
        .strike_pulse (strike_pulse),
        .seconds_left (seconds_left),
        .second_tick  (second_tick)
    );

    always #5 clock = ~clock;

    // Reference LFSR; m_prev is the value the DUT saw at the most recent edge.
    always @(posedge clock) begin
        m_prev <= m_lfsr;
        if (reset) m_lfsr <= SEED;
        else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_state"},   32'(game_state),        32'd0);
        check({tag, "_enable"},  32'(bus.module_enable), 32'd0);
        check({tag, "_load"},    32'(bus.rng_load),      32'd0);
        check({tag, "_rng"},     32'(bus.rng_output),    32'd0);
        check({tag, "_strikes"}, 32'(strikes),           32'd0);
        check({tag, "_pulse"},   32'(strike_pulse),      32'd0);
        check({tag, "_tick"},    32'(second_tick),       32'd0);
        check({tag, "_secs"},    32'(seconds_left),      32'd3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        start = 1'b0;
        bus.module_strike  = '0;
        bus.module_defused = '0;
        cyc(1);
        reset = 1'b0;
    endtask

    // Leaves the bench 1 ns after the edge that enters ARMED.
    task automatic begin_game();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        bus.module_strike  = '0;
        bus.module_defused = '0;
        cyc(2);
        check_reset("por");
        reset = 1'b0;

        // Setup sequence; start held high throughout must be ignored.
        start = 1'b1;
        cyc(1);
        for (int k = 0; k < NM; k++) begin
            check("setup_state", 32'(game_state),        32'd1);
            check("setup_load",  32'(bus.rng_load),      32'd1 << k);
            check("setup_rng",   32'(bus.rng_output),    32'(m_prev[3:0]));
            check("setup_enable", 32'(bus.module_enable), 32'd0);
            last_rng = m_prev[3:0];
            cyc(1);
        end
        start = 1'b0;
        check("armed_state",  32'(game_state),        32'd2);
        check("armed_enable", 32'(bus.module_enable), 32'hF);
        check("armed_load",   32'(bus.rng_load),      32'd0);
        check("armed_rng",    32'(bus.rng_output),    32'(last_rng));
        check("armed_secs",   32'(seconds_left),      32'd3);

        // Timeout
        do_reset();
        begin_game();
        cyc(9);
        check("to_tick_early", 32'(second_tick),  32'd0);
        check("to_secs3",      32'(seconds_left), 32'd3);
        cyc(1);
        check("to_tick1",      32'(second_tick),  32'd1);
        check("to_secs2",      32'(seconds_left), 32'd2);
        cyc(1);
        check("to_tick_drop",  32'(second_tick),  32'd0);
        cyc(9);
        check("to_tick2",      32'(second_tick),  32'd1);
        check("to_secs1",      32'(seconds_left), 32'd1);
        check("to_state_arm",  32'(game_state),   32'd2);
        cyc(10);
        check("to_tick3",      32'(second_tick),  32'd1);
        check("to_secs0",      32'(seconds_left), 32'd0);
        check("to_exploded",   32'(game_state),   32'd4);
        check("to_enable",     32'(bus.module_enable), 32'd0);
        cyc(20);
        check("to_no_tick",    32'(second_tick),  32'd0);
        check("to_secs_hold",  32'(seconds_left), 32'd0);
        check("to_state_hold", 32'(game_state),   32'd4);

        // Strike counting
        do_reset();
        begin_game();
        bus.module_strike = 4'b0010;
        cyc(1);
        check("st_cnt1",   32'(strikes),      32'd1);
        check("st_pulse1", 32'(strike_pulse), 32'd1);
        cyc(1);
        check("st_pulse_drop", 32'(strike_pulse), 32'd0);
        cyc(3);
        check("st_held",   32'(strikes),      32'd1);
        bus.module_strike = 4'b0100;
        cyc(1);
        check("st_cnt2",   32'(strikes),      32'd2);
        check("st_pulse2", 32'(strike_pulse), 32'd1);
        cyc(1);
        check("st_pulse_drop2", 32'(strike_pulse), 32'd0);
        bus.module_strike = 4'b1101;
        cyc(1);
        check("st_sat",     32'(strikes),      32'd3);
        check("st_pulse3",  32'(strike_pulse), 32'd1);
        check("st_explode", 32'(game_state),   32'd4);
        check("st_enable",  32'(bus.module_enable), 32'd0);
        bus.module_strike = 4'b0000;
        cyc(1);
        bus.module_strike = 4'b0001;
        cyc(1);
        check("st_frozen",  32'(strikes),      32'd3);
        check("st_no_pulse", 32'(strike_pulse), 32'd0);

        // Defuse
        do_reset();
        begin_game();
        bus.module_defused = 4'b0001;
        cyc(1);
        bus.module_defused = 4'b0011;
        cyc(1);
        bus.module_defused = 4'b0111;
        cyc(1);
        check("df_partial", 32'(game_state), 32'd2);
        bus.module_defused = 4'b1111;
        cyc(1);
        check("df_state",   32'(game_state),        32'd3);
        check("df_enable",  32'(bus.module_enable), 32'd0);
        check("df_secs",    32'(seconds_left),      32'd3);
        start = 1'b1;
        cyc(15);
        start = 1'b0;
        check("df_secs_frozen", 32'(seconds_left), 32'd3);
        check("df_state_hold",  32'(game_state),   32'd3);
        check("df_no_tick",     32'(second_tick),  32'd0);

        // Explosion beats defuse in the same cycle
        do_reset();
        begin_game();
        bus.module_defused = 4'b0111;
        bus.module_strike  = 4'b0001;
        cyc(1);
        check("pr_cnt1", 32'(strikes), 32'd1);
        bus.module_strike  = 4'b0011;
        cyc(1);
        check("pr_cnt2", 32'(strikes), 32'd2);
        bus.module_defused = 4'b1111;
        bus.module_strike  = 4'b0111;
        cyc(1);
        check("pr_state",   32'(game_state), 32'd4);
        check("pr_strikes", 32'(strikes),    32'd3);

        // Reset during SETUP step 2
        do_reset();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(2);
        check("rs_setup_state", 32'(game_state),   32'd1);
        check("rs_setup_load",  32'(bus.rng_load), 32'b0100);
        reset = 1'b1;
        cyc(1);
        check_reset("rs_setup");
        reset = 1'b0;

        // Reset in ARMED with two strikes, strike level held through reset
        begin_game();
        bus.module_strike = 4'b0001;
        cyc(1);
        bus.module_strike = 4'b0011;
        cyc(1);
        check("rs_arm_cnt2", 32'(strikes), 32'd2);
        reset = 1'b1;
        cyc(1);
        check_reset("rs_armed");
        reset = 1'b0;
        begin_game();
        check("rs_held_state", 32'(game_state),   32'd2);
        check("rs_held_cnt",   32'(strikes),      32'd0);
        check("rs_held_pulse", 32'(strike_pulse), 32'd0);
        cyc(3);
        check("rs_held_cnt_later", 32'(strikes),  32'd0);
        bus.module_strike = 4'b0111;
        cyc(1);
        check("rs_new_cnt",   32'(strikes),      32'd1);
        check("rs_new_pulse", 32'(strike_pulse), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
